div_sched_ctrl: RTL

Programmable divide-by-N tick scheduler with start/stop sequencing and a glitch-free divisor reconfiguration handshake. It generalises the team's fixed divide-by-3 FSM into a runtime-configurable controller. It sits between the control/config path and any logic that needs a periodic one-cycle enable pulse. Divisor changes requested while running never take effect mid-period; they are applied at a period boundary.

---
 rtl/div_sched_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/div_sched_ctrl.sv
// div_sched_ctrl
// Programmable divide-by-N tick scheduler. While running it emits a one-cycle
// tick at the start of every divisor period. Start/stop are level-sampled, and
// a stop always finishes the current period before the block goes idle.
// Divisor changes offered while running are held in a one-deep pending slot
// and only take effect at a period boundary, so no period is ever cut short or
// stretched.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   start      : start request (level)
//   stop       : stop request (level, wins over start in IDLE)
//   cfg_valid  : new divisor offered on cfg_div
//   cfg_div    : offered divisor (valid range 2 .. 2^CW-1)
//   cfg_ready  : a divisor can be accepted this cycle
//   tick       : one-cycle pulse at phase 0 while running
//   busy       : controller is not idle
//   phase      : position in the current period, 0 .. div_q-1
//   div_q      : divisor currently in force
//   err        : one-cycle pulse after an accepted-but-invalid divisor
module div_sched_ctrl #(
  parameter int CW        = 8,
  parameter int RESET_DIV = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_div,
  output logic          cfg_ready,
  output logic          tick,
  output logic          busy,
  output logic [CW-1:0] phase,
  output logic [CW-1:0] div_q,
  output logic          err
);

  localparam logic [CW-1:0] ResetDiv = CW'(RESET_DIV);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [CW-1:0] div_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic          tick_q, busy_q, ready_q, err_q;

  logic          wrap;
  logic          xfer;
  logic          bad_div;

  // A period ends when the phase reaches the last slot of the divisor in force.
  assign wrap    = (phase_q == div_q - CW'(1));
  assign xfer    = cfg_valid && ready_q;
  assign bad_div = (cfg_div < CW'(2));

  // Next-state logic. The outputs are registered from the next state below,
  // which keeps tick/busy/cfg_ready pure functions of the registered state.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    div_d        = div_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (xfer && !bad_div) begin
          div_d = cfg_div;
        end
        if (start && !stop) begin
          state_d = RUN;
        end
      end

      RUN, STOPPING: begin
        phase_d = wrap ? '0 : phase_q + CW'(1);

        // Pending is only ever loaded when empty, so an apply at this wrap
        // and a new transfer in the same cycle cannot collide. A transfer in
        // the wrap cycle itself lands in pending and waits for the next wrap.
        if (wrap && pend_valid_q) begin
          div_d        = pend_q;
          pend_valid_d = 1'b0;
        end
        if (xfer && !bad_div) begin
          pend_d       = cfg_div;
          pend_valid_d = 1'b1;
        end

        if (state_q == RUN) begin
          if (stop) begin
            state_d = STOPPING;
          end
        end else begin
          // Resuming takes priority over finishing the wind-down period.
          if (start && !stop) begin
            state_d = RUN;
          end else if (wrap) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Single state register, including the registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      div_q        <= ResetDiv;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      div_q        <= div_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= (state_d == RUN) && (phase_d == '0);
      busy_q       <= (state_d != IDLE);
      ready_q      <= (state_d == IDLE) || !pend_valid_d;
      err_q        <= xfer && bad_div;
    end
  end

  assign tick      = tick_q;
  assign busy      = busy_q;
  assign cfg_ready = ready_q;
  assign phase     = phase_q;
  assign err       = err_q;

endmodule
